// File: rtl/spike_synapse_pkg.sv
// Shared types, widths and saturating arithmetic for the spike_synapse block.
package spike_synapse_pkg;

   localparam int                DATA_W  = 8;
   localparam logic [DATA_W-1:0] SAT_MAX = 8'd255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LISTEN,
      ST_REFRACT
   } state_t;

   // Sum is formed one bit wider so the carry-out selects the clamp.
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[DATA_W] ? SAT_MAX : sum[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] a);
      return (a == SAT_MAX) ? SAT_MAX : a + DATA_W'(1);
   endfunction

endpackage

// File: rtl/syn_decay.sv
// Free-running decay divider plus the shift/subtract step that pulls the
// synaptic current toward zero, removing at least 1 while it is non-zero.
module syn_decay
   import spike_synapse_pkg::*;
#(
   parameter int DECAY_PERIOD = 16,
   parameter int DECAY_SHIFT  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] level,
   output logic              tick,
   output logic [DATA_W-1:0] decayed
);

   localparam int               DIV_W    = $clog2(DECAY_PERIOD);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_PERIOD - 1);

   logic [DIV_W-1:0]  div;
   logic [DATA_W-1:0] step;

   // NOTE: registers take <= so every flop samples pre-edge values; always_comb
   // blocks assign each output a default first so no latch is inferred.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   assign tick = (div == DIV_LAST);

   // Without the floor of 1 a small current would stick below 2**DECAY_SHIFT.
   always_comb begin
      step = level >> DECAY_SHIFT;
      if (step == '0 && level != '0) begin
         step = DATA_W'(1);
      end
      decayed = tick ? (level - step) : level;
   end

endmodule

// File: rtl/spike_synapse.sv
// Spike receiver: edge detect, refractory FSM, decaying weighted current,
// spike counter and optional ISI measurement (macro SPIKE_SYNAPSE_ISI_EN).
module spike_synapse
   import spike_synapse_pkg::*;
#(
   parameter int DECAY_PERIOD = 16,
   parameter int DECAY_SHIFT  = 3,
   parameter int REFRACT      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spike_in,
   input  logic [DATA_W-1:0] weight,
   output logic [DATA_W-1:0] current,
   output logic [DATA_W-1:0] spike_count,
   output logic [DATA_W-1:0] isi,
   output logic              isi_valid
);

   localparam int              RC_W    = (REFRACT > 1) ? $clog2(REFRACT) : 1;
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [RC_W-1:0]   rcnt;
   logic [RC_W-1:0]   rcnt_nxt;
   logic              spike_prev;
   logic              edge_det;
   logic              accept;
   logic              decay_tick;
   logic [DATA_W-1:0] decayed;

   assign edge_det = spike_in & ~spike_prev;

   syn_decay #(
      .DECAY_PERIOD(DECAY_PERIOD),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_decay (
      .clk    (clk),
      .rst_n  (rst_n),
      .level  (current),
      .tick   (decay_tick),
      .decayed(decayed)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rcnt       <= '0;
         spike_prev <= 1'b0;
      end else begin
         state      <= state_nxt;
         rcnt       <= rcnt_nxt;
         spike_prev <= spike_in;
      end
   end

   // Refractory window spans exactly REFRACT cycles after the accepting edge.
   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      accept    = 1'b0;
      unique case (state)
         ST_IDLE, ST_LISTEN: begin
            if (edge_det) begin
               accept    = 1'b1;
               state_nxt = ST_REFRACT;
               rcnt_nxt  = RC_LOAD;
            end
         end
         ST_REFRACT: begin
            if (rcnt == '0) begin
               state_nxt = ST_LISTEN;
            end else begin
               rcnt_nxt = rcnt - RC_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Decay is applied before the weight is added on a coincident tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current     <= '0;
         spike_count <= '0;
      end else begin
         if (accept) begin
            current     <= sat_add(decayed, weight);
            spike_count <= sat_inc(spike_count);
         end else if (decay_tick) begin
            current <= decayed;
         end
      end
   end

`ifdef SPIKE_SYNAPSE_ISI_EN
   logic              report;
   logic [DATA_W-1:0] isi_cnt;

   // The first spike after reset has no predecessor, so only LISTEN reports.
   assign report = accept && (state == ST_LISTEN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi_cnt   <= '0;
         isi       <= '0;
         isi_valid <= 1'b0;
      end else begin
         isi_valid <= report;
         if (report) begin
            isi <= sat_inc(isi_cnt);
         end
         if (accept) begin
            isi_cnt <= '0;
         end else begin
            isi_cnt <= sat_inc(isi_cnt);
         end
      end
   end
`else
   assign isi       = '0;
   assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: directed table, corner sequences and
// randomized stimulus against a time-stamp based reference model.
module tb_spike_synapse;

   localparam int DP = 16;
   localparam int DS = 3;
   localparam int RF = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spike_in = 1'b0;
   logic [7:0] weight = 8'd0;
   logic [7:0] current;
   logic [7:0] spike_count;
   logic [7:0] isi;
   logic       isi_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cycle index since reset and time of last accepted spike.
   int m_n;
   int m_last;
   int m_cur;
   int m_cnt;
   int m_isi;
   int m_valid;
   bit m_prev;

   typedef struct {
      logic       spike;
      logic [7:0] weight;
      int         exp_current;
      int         exp_count;
   } vec_t;

   vec_t tbl[10];

   spike_synapse #(
      .DECAY_PERIOD(DP),
      .DECAY_SHIFT (DS),
      .REFRACT     (RF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike_in   (spike_in),
      .weight     (weight),
      .current    (current),
      .spike_count(spike_count),
      .isi        (isi),
      .isi_valid  (isi_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   function automatic int exp_isi();
`ifdef SPIKE_SYNAPSE_ISI_EN
      return m_isi;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_valid();
`ifdef SPIKE_SYNAPSE_ISI_EN
      return m_valid;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_n     = 0;
      m_last  = -1;
      m_cur   = 0;
      m_cnt   = 0;
      m_isi   = 0;
      m_valid = 0;
      m_prev  = 1'b0;
   endtask

   // Called at a negedge; drives inputs, advances one clock, compares at the next negedge.
   task automatic step(input logic s, input logic [7:0] w);
      bit edge_seen;
      int d;
      spike_in = s;
      weight   = w;
      @(posedge clk);
      edge_seen = s && !m_prev;
      m_prev    = s;
      if ((m_n % DP) == DP - 1) begin
         d = m_cur >> DS;
         if (d == 0 && m_cur != 0) d = 1;
         m_cur = m_cur - d;
      end
      m_valid = 0;
      if (edge_seen && (m_last < 0 || m_n - m_last > RF)) begin
         m_cur = (m_cur + w > 255) ? 255 : m_cur + w;
         m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
         if (m_last >= 0) begin
            m_isi   = (m_n - m_last > 255) ? 255 : m_n - m_last;
            m_valid = 1;
         end
         m_last = m_n;
      end
      m_n++;
      @(negedge clk);
      check("model_current", current, m_cur);
      check("model_count", spike_count, m_cnt);
      check("model_isi", isi, exp_isi());
      check("model_isi_valid", isi_valid, exp_valid());
   endtask

   task automatic do_reset();
      spike_in = 1'b0;
      weight   = 8'd0;
      rst_n    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_current", current, 0);
      check("rst_count", spike_count, 0);
      check("rst_isi", isi, 0);
      check("rst_isi_valid", isi_valid, 0);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < 10; i++) begin
         tbl[i] = '{spike: (i == 5), weight: 8'd40,
                    exp_current: (i >= 5) ? 40 : 0, exp_count: (i >= 5) ? 1 : 0};
      end

      // Single pulse at cycle 5, then the 40 -> 35 -> 31 -> 28 decay chain.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].spike, tbl[i].weight);
         check("tbl_current", current, tbl[i].exp_current);
         check("tbl_count", spike_count, tbl[i].exp_count);
         check("tbl_isi_valid", isi_valid, 0);
      end
      for (int i = 10; i < 48; i++) begin
         step(1'b0, 8'd0);
         if (i == 14) check("decay_pre_tick", current, 40);
         if (i == 15) check("decay_tick1", current, 35);
         if (i == 31) check("decay_tick2", current, 31);
         if (i == 47) check("decay_tick3", current, 28);
      end

      // Small current decays by the floor of 1 down to 0 and stays there.
      do_reset();
      step(1'b1, 8'd5);
      for (int i = 1; i <= 100; i++) begin
         step(1'b0, 8'd0);
         if (i == 15) check("floor_4", current, 4);
         if (i == 31) check("floor_3", current, 3);
         if (i == 47) check("floor_2", current, 2);
         if (i == 63) check("floor_1", current, 1);
         if (i == 79) check("floor_0", current, 0);
         if (i == 100) check("floor_stay0", current, 0);
      end

      // Held spike line counts once.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 8'd25);
      step(1'b0, 8'd25);
      check("held_count", spike_count, 1);
      check("held_current", current, 25);

      // Saturation and ISI of 10.
      do_reset();
      step(1'b1, 8'd200);
      for (int i = 1; i < 10; i++) step(1'b0, 8'd200);
      step(1'b1, 8'd200);
      check("sat_current", current, 255);
      check("sat_count", spike_count, 2);
`ifdef SPIKE_SYNAPSE_ISI_EN
      check("isi_10", isi, 10);
      check("isi_valid_on", isi_valid, 1);
`endif
      step(1'b0, 8'd0);
      check("isi_valid_one_cycle", isi_valid, 0);

      // Edges at t+2 and t+4 fall inside the refractory window.
      do_reset();
      step(1'b1, 8'd30);
      step(1'b0, 8'd30);
      step(1'b1, 8'd30);
      check("refract_t2_count", spike_count, 1);
      check("refract_t2_current", current, 30);
      step(1'b0, 8'd30);
      step(1'b1, 8'd30);
      check("refract_last_cycle", spike_count, 1);

      // Edge in the first LISTEN cycle is accepted.
      do_reset();
      step(1'b1, 8'd30);
      for (int i = 1; i < 5; i++) step(1'b0, 8'd30);
      step(1'b1, 8'd30);
      check("listen_first_count", spike_count, 2);
      check("listen_first_current", current, 60);

      // Long gap saturates the interval.
      do_reset();
      step(1'b1, 8'd10);
      for (int i = 1; i < 300; i++) step(1'b0, 8'd10);
      step(1'b1, 8'd10);
`ifdef SPIKE_SYNAPSE_ISI_EN
      check("isi_sat", isi, 255);
`else
      check("isi_tied0", isi, 0);
`endif

      // Asynchronous reset in the middle of REFRACT.
      do_reset();
      step(1'b1, 8'd120);
      step(1'b0, 8'd120);
      check("pre_rst_current", current, 120);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_current", current, 0);
      check("async_rst_count", spike_count, 0);
      check("async_rst_isi", isi, 0);
      check("async_rst_isi_valid", isi_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 8'd50);
      check("post_rst_current", current, 50);
      check("post_rst_count", spike_count, 1);
      check("post_rst_no_valid", isi_valid, 0);

      // Randomized traffic against the model, with occasional resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic       s;
         logic [7:0] w;
         s = ($urandom_range(0, 2) == 0);
         w = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, 20));
         if ($urandom_range(0, 599) == 0) do_reset();
         step(s, w);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
